mem_access_ctrl: RTL and testbench

//   Clocked front-end sitting directly upstream of the general memory block.

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/mem_access_ctrl_sat_counter.sv | 22 ++
 rtl/mem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM states and
// the memory readWrite pin encoding.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/mem_access_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             clear,
    input  logic             inc,
    output logic [width-1:0] count
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request/response front-end that sequences a level-sensitive memory's
// enable/readWrite pins with a setup cycle before every strobe.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter  int unsigned wordSize   = 4,
    parameter  int unsigned numWords   = 64,
    parameter  int unsigned countWidth = 16,
    localparam int unsigned addrW      = $clog2(numWords)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [addrW-1:0]      reqAddr,
    input  logic [wordSize-1:0]   reqData,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic [wordSize-1:0]   rspData,
    output logic                  rspErr,
    output logic                  memEnable,
    output logic                  memReadWrite,
    output logic [addrW-1:0]      memAddress,
    output logic [wordSize-1:0]   memDataIn,
    input  logic [wordSize-1:0]   memDataOut,
    input  logic                  countClear,
    output logic [countWidth-1:0] rdCount,
    output logic [countWidth-1:0] wrCount
);

    state_t state;
    logic   opWrite;
    logic   opInRange;
    logic   reqInRange;
    logic   rdInc;
    logic   wrInc;

    // One extra bit so a power-of-two depth still compares correctly.
    assign reqInRange = {1'b0, reqAddr} < (addrW + 1)'(numWords);

    // Counters advance on the edge that completes the access.
    assign wrInc = (state == STROBE) && opWrite;
    assign rdInc = (state == CAPTURE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            reqReady     <= 1'b0;
            opWrite      <= 1'b0;
            opInRange    <= 1'b0;
            memEnable    <= 1'b0;
            memReadWrite <= MEM_READ;
            memAddress   <= '0;
            memDataIn    <= '0;
            rspValid     <= 1'b0;
            rspData      <= '0;
            rspErr       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid && reqReady) begin
                        reqReady  <= 1'b0;
                        opWrite   <= reqWrite;
                        opInRange <= reqInRange;
                        state     <= SETUP;
                        // Out-of-range requests never touch the memory pins.
                        if (reqInRange) begin
                            memAddress   <= reqAddr;
                            memDataIn    <= reqData;
                            memReadWrite <= reqWrite ? MEM_WRITE : MEM_READ;
                        end
                    end else begin
                        reqReady <= 1'b1;
                    end
                end
                SETUP: begin
                    if (opInRange) begin
                        memEnable <= 1'b1;
                        state     <= STROBE;
                    end else if (opWrite) begin
                        reqReady <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        rspValid <= 1'b1;
                        rspData  <= '0;
                        rspErr   <= 1'b1;
                        state    <= RESP;
                    end
                end
                STROBE: begin
                    if (opWrite) begin
                        memEnable <= 1'b0;
                        reqReady  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rspData   <= memDataOut;
                    rspErr    <= 1'b0;
                    rspValid  <= 1'b1;
                    memEnable <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        reqReady <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.width(countWidth)) u_rd_counter (
        .clk   (clk),
        .rstN  (rstN),
        .clear (countClear),
        .inc   (rdInc),
        .count (rdCount)
    );

    sat_counter #(.width(countWidth)) u_wr_counter (
        .clk   (clk),
        .rstN  (rstN),
        .clear (countClear),
        .inc   (wrInc),
        .count (wrCount)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of request vectors, response scoreboard,
// memory model with pin-timing checker, and hand sequences for corner cases.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rstN;
    logic       reqValid, reqReady, reqWrite;
    logic [5:0] reqAddr;
    logic [3:0] reqData;
    logic       rspValid;
    logic       rspReady = 1'b1;
    logic [3:0] rspData;
    logic       rspErr;
    logic       memEnable, memReadWrite;
    logic [5:0] memAddress;
    logic [3:0] memDataIn, memDataOut;
    logic       countClear;
    logic [1:0] rdCount, wrCount;

    mem_access_ctrl #(.wordSize(4), .numWords(48), .countWidth(2)) dut (
        .clk(clk), .rstN(rstN),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqData(reqData),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr),
        .memEnable(memEnable), .memReadWrite(memReadWrite), .memAddress(memAddress),
        .memDataIn(memDataIn), .memDataOut(memDataOut),
        .countClear(countClear), .rdCount(rdCount), .wrCount(wrCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic       err;
    } rsp_t;

    typedef struct {
        bit         w;
        logic [5:0] a;
        logic [3:0] d;
        logic [3:0] expData;
        bit         expErr;
        int         expEn;
        logic [1:0] expWr;
        logic [1:0] expRd;
    } vec_t;

    rsp_t       q[$];
    logic [3:0] phys [64];
    logic [3:0] refm [64];
    int         nvec = 0;
    int         nerr = 0;
    int         enCnt = 0;
    int         enRun = 0;
    bit         randReady = 1'b0;
    bit         rspReadyForce = 1'b1;
    logic [1:0] expWr, expRd;

    // Memory: reads are combinational while enabled, writes commit on a clock
    // edge seen with enable high, so a strobe cut short by reset writes nothing.
    assign memDataOut = (memEnable && memReadWrite) ? phys[memAddress] : 4'h0;
    always @(posedge clk) if (memEnable && !memReadWrite) phys[memAddress] <= memDataIn;

    always @(negedge clk) rspReady = randReady ? 1'($urandom_range(0, 1)) : rspReadyForce;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    // Pin-timing checker and response scoreboard.
    logic       prevEn = 1'b0, prevRw = 1'b1, prevRst = 1'b0;
    logic [5:0] prevAddr = '0;
    logic [3:0] prevDin = '0;
    always begin
        rsp_t e;
        @(negedge clk); #1;
        if (memEnable) begin enCnt++; enRun++; end
        else enRun = 0;
        if (rstN && prevRst && (memEnable || prevEn)) begin
            chk("pin_addr_stable", memAddress, prevAddr);
            chk("pin_rw_stable", memReadWrite, prevRw);
            chk("pin_din_stable", memDataIn, prevDin);
        end
        if (memEnable) chk("enable_run_le2", enRun <= 2, 1);
        if (rstN && rspValid && rspReady) begin
            if (q.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_rsp: got data %0h err %0b expected no response", rspData, rspErr);
            end else begin
                e = q.pop_front();
                chk("rsp_data", rspData, e.data);
                chk("rsp_err", rspErr, e.err);
            end
        end
        prevEn = memEnable; prevRw = memReadWrite; prevAddr = memAddress;
        prevDin = memDataIn; prevRst = rstN;
    end

    // Called at negedge+2; returns at negedge+2 after the accept edge.
    task automatic do_req(input bit w, input logic [5:0] a, input logic [3:0] d);
        int n = 0;
        reqValid = 1'b1; reqWrite = w; reqAddr = a; reqData = d;
        while (!reqReady && n < 200) begin @(negedge clk); #2; n++; end
        if (!reqReady) begin
            nvec++; nerr++;
            $display("FAIL req_accept_timeout: got reqReady 0 expected 1 within 200 cycles");
            reqValid = 1'b0;
            return;
        end
        @(negedge clk); #2;
        reqValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(reqReady && q.size() == 0) && n < 200) begin @(negedge clk); #2; n++; end
        if (!(reqReady && q.size() == 0)) begin
            nvec++; nerr++;
            $display("FAIL idle_timeout: got reqReady %0b pending %0d expected idle", reqReady, q.size());
        end
    endtask

    task automatic wait_enable();
        int n = 0;
        while (!memEnable && n < 20) begin @(negedge clk); #2; n++; end
        chk("strobe_reached", memEnable, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within 2ms");
        $fatal(1, "watchdog");
    end

    vec_t vt[14];
    initial begin
        bit         w, inr;
        logic [5:0] a;
        logic [3:0] d;
        int         e0;

        //        w  addr   data  expD  eErr en wr    rd
        vt[0]  = '{1, 6'd5,  4'hA, 4'h0, 0, 1, 2'd1, 2'd0};
        vt[1]  = '{0, 6'd5,  4'h0, 4'hA, 0, 2, 2'd1, 2'd1};
        vt[2]  = '{0, 6'd50, 4'h0, 4'h0, 1, 0, 2'd1, 2'd1};
        vt[3]  = '{1, 6'd50, 4'h6, 4'h0, 0, 0, 2'd1, 2'd1};
        vt[4]  = '{0, 6'd63, 4'h0, 4'h0, 1, 0, 2'd1, 2'd1};
        vt[5]  = '{1, 6'd48, 4'h1, 4'h0, 0, 0, 2'd1, 2'd1};
        vt[6]  = '{0, 6'd48, 4'h0, 4'h0, 1, 0, 2'd1, 2'd1};
        vt[7]  = '{1, 6'd0,  4'h3, 4'h0, 0, 1, 2'd2, 2'd1};
        vt[8]  = '{1, 6'd47, 4'hF, 4'h0, 0, 1, 2'd3, 2'd1};
        vt[9]  = '{0, 6'd0,  4'h0, 4'h3, 0, 2, 2'd3, 2'd2};
        vt[10] = '{0, 6'd47, 4'h0, 4'hF, 0, 2, 2'd3, 2'd3};
        vt[11] = '{1, 6'd1,  4'h5, 4'h0, 0, 1, 2'd3, 2'd3};
        vt[12] = '{0, 6'd1,  4'h0, 4'h5, 0, 2, 2'd3, 2'd3};
        vt[13] = '{0, 6'd5,  4'h0, 4'hA, 0, 2, 2'd3, 2'd3};

        for (int i = 0; i < 64; i++) begin phys[i] = 4'h0; refm[i] = 4'h0; end
        rstN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqData = '0;
        countClear = 1'b0;
        repeat (3) @(negedge clk); #2;

        chk("rst_memEnable", memEnable, 0);
        chk("rst_memReadWrite", memReadWrite, 1);
        chk("rst_memAddress", memAddress, 0);
        chk("rst_memDataIn", memDataIn, 0);
        chk("rst_reqReady", reqReady, 0);
        chk("rst_rspValid", rspValid, 0);
        chk("rst_rspData", rspData, 0);
        chk("rst_rspErr", rspErr, 0);
        chk("rst_rdCount", rdCount, 0);
        chk("rst_wrCount", wrCount, 0);
        rstN = 1'b1;
        @(negedge clk); #2;
        chk("ready_after_reset", reqReady, 1);

        // Vector table: writes/reads, out-of-range drops, boundary 47/48, saturation.
        for (int i = 0; i < 14; i++) begin
            e0 = enCnt;
            if (!vt[i].w) q.push_back(rsp_t'{vt[i].expData, vt[i].expErr});
            else if (vt[i].a < 6'd48) refm[vt[i].a] = vt[i].d;
            do_req(vt[i].w, vt[i].a, vt[i].d);
            wait_idle();
            chk($sformatf("vec%0d_enable_cycles", i), enCnt - e0, vt[i].expEn);
            chk($sformatf("vec%0d_wrCount", i), wrCount, vt[i].expWr);
            chk($sformatf("vec%0d_rdCount", i), rdCount, vt[i].expRd);
        end
        expWr = 2'd3; expRd = 2'd3;

        // Response back-pressure: data held for 6 cycles with no new request accepted.
        rspReadyForce = 1'b0;
        @(negedge clk); #2;
        q.push_back(rsp_t'{4'hA, 1'b0});
        do_req(1'b0, 6'd5, 4'h0);
        for (int n = 0; n < 20 && !rspValid; n++) begin @(negedge clk); #2; end
        for (int n = 0; n < 6; n++) begin
            chk("hold_rspValid", rspValid, 1);
            chk("hold_rspData", rspData, 4'hA);
            chk("hold_reqReady", reqReady, 0);
            @(negedge clk); #2;
        end
        rspReadyForce = 1'b1;
        @(negedge clk); #2;
        chk("hold_last_rspValid", rspValid, 1);
        @(negedge clk); #2;
        chk("release_rspValid", rspValid, 0);
        chk("release_reqReady", reqReady, 1);

        // Reset during the strobe of a write: the write must not land.
        refm[7] = 4'h3;
        do_req(1'b1, 6'd7, 4'h3);
        wait_idle();
        do_req(1'b1, 6'd7, 4'hC);
        wait_enable();
        rstN = 1'b0;
        #1;
        chk("midrst_memEnable", memEnable, 0);
        chk("midrst_memReadWrite", memReadWrite, 1);
        chk("midrst_memAddress", memAddress, 0);
        chk("midrst_reqReady", reqReady, 0);
        chk("midrst_wrCount", wrCount, 0);
        @(negedge clk); #2;
        rstN = 1'b1;
        expWr = 2'd0; expRd = 2'd0;
        @(negedge clk); #2;
        chk("midrst_ready", reqReady, 1);
        q.push_back(rsp_t'{refm[7], 1'b0});
        expRd = sat_inc(expRd);
        do_req(1'b0, 6'd7, 4'h0);
        wait_idle();
        chk("midrst_rdCount", rdCount, expRd);
        chk("midrst_wrCount_after", wrCount, expWr);

        // Write counter saturation, then clear on the same edge as a completion.
        for (int i = 0; i < 5; i++) begin
            refm[10 + i] = 4'(i + 1);
            expWr = sat_inc(expWr);
            do_req(1'b1, 6'(10 + i), 4'(i + 1));
            wait_idle();
            chk($sformatf("sat_wrCount%0d", i), wrCount, expWr);
        end
        refm[15] = 4'h9;
        do_req(1'b1, 6'd15, 4'h9);
        wait_enable();
        countClear = 1'b1;
        @(negedge clk); #2;
        countClear = 1'b0;
        chk("clear_wins_wrCount", wrCount, 0);
        chk("clear_rdCount", rdCount, 0);
        chk("clear_reqReady", reqReady, 1);
        expWr = 2'd0; expRd = 2'd0;

        // Random back-to-back traffic with random response back-pressure.
        randReady = 1'b1;
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(48, 63)) : 6'($urandom_range(0, 47));
            d = 4'($urandom_range(0, 15));
            inr = (a < 6'd48);
            if (w) begin
                if (inr) begin refm[a] = d; expWr = sat_inc(expWr); end
            end else begin
                q.push_back(rsp_t'{inr ? refm[a] : 4'h0, !inr});
                if (inr) expRd = sat_inc(expRd);
            end
            do_req(w, a, d);
        end
        randReady = 1'b0;
        rspReadyForce = 1'b1;
        wait_idle();
        chk("rand_wrCount", wrCount, expWr);
        chk("rand_rdCount", rdCount, expRd);
        chk("rand_rsp_pending", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
